// File: rtl/cpu_run_ctrl_pkg.sv
// Shared definitions for the CPU run/halt/step sequencer: host command opcodes,
// sequencer states, halt-cause codes and the default halt opcode.
package cpu_run_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_RST  = 3'd0,
        ST_HALT = 3'd1,
        ST_RUN  = 3'd2,
        ST_STEP = 3'd3,
        ST_STOP = 3'd4
    } state_e;

    typedef enum logic [2:0] {
        CMD_NOP       = 3'd0,
        CMD_RUN       = 3'd1,
        CMD_HALT      = 3'd2,
        CMD_STEP      = 3'd3,
        CMD_CPU_RESET = 3'd4,
        CMD_SET_BP    = 3'd5,
        CMD_CLR_BP    = 3'd6,
        CMD_RSVD      = 3'd7
    } cmd_e;

    localparam logic [1:0] CAUSE_CMD  = 2'd0;
    localparam logic [1:0] CAUSE_BRK  = 2'd1;
    localparam logic [1:0] CAUSE_STEP = 2'd2;
    localparam logic [1:0] CAUSE_HLT  = 2'd3;

    localparam logic [7:0] HLT_OPCODE_DEF = 8'hFF;

endpackage

// File: rtl/cpu_run_ctrl.sv
// Run/halt/step sequencer between host and single-cycle core: gates the core with
// cpu_en, drives its pc_rst and stops it on breakpoint, step expiry or HLT opcode.
module cpu_run_ctrl
    import cpu_run_ctrl_pkg::*;
#(
    parameter int                 WIDTH      = 8,
    parameter int                 CNT_WIDTH  = 16,
    parameter int                 RST_CYCLES = 2,
    parameter logic [WIDTH-1:0]   HLT_OPCODE = WIDTH'(HLT_OPCODE_DEF)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [2:0]           cmd_op,
    input  logic [WIDTH-1:0]     cmd_arg,
    input  logic [WIDTH-1:0]     pc,
    input  logic [WIDTH-1:0]     instr,
    output logic                 cpu_en,
    output logic                 cpu_rst,
    output logic                 halted,
    output logic [1:0]           halt_cause,
    output logic [CNT_WIDTH-1:0] retired
);

    localparam int                RC_W     = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [RC_W-1:0]   RST_LOAD = RC_W'(RST_CYCLES - 1);
    localparam logic [WIDTH-1:0]  STEP_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_e                 state_q, state_d;
    logic [RC_W-1:0]        rst_cnt_q, rst_cnt_d;
    logic [1:0]             halt_cause_q, halt_cause_d;
    logic [CNT_WIDTH-1:0]   retired_q, retired_d;
    logic [WIDTH-1:0]       step_cnt_q, step_cnt_d;
    logic                   bp_en_q, bp_en_d;
    logic [WIDTH-1:0]       bp_addr_q, bp_addr_d;
    logic                   skip_q, skip_d;
    logic                   cpu_rst_q, cpu_rst_d;
    logic                   halted_q, halted_d;
    logic                   cmd_ready_q, cmd_ready_d;

    logic                   brk_s;
    logic                   hlt_s;
    logic                   fire_s;
    cmd_e                   op_s;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    endfunction

    // Next-state, counters and breakpoint bookkeeping; CPU_RESET overrides every event.
    always_comb begin
        brk_s  = bp_en_q && (pc == bp_addr_q) && !skip_q;
        hlt_s  = (instr == HLT_OPCODE);
        cpu_en = ((state_q == ST_RUN) || (state_q == ST_STEP)) && !brk_s && !hlt_s;
        fire_s = cmd_valid && cmd_ready_q;
        op_s   = cmd_e'(cmd_op);

        state_d      = state_q;
        rst_cnt_d    = rst_cnt_q;
        halt_cause_d = halt_cause_q;
        retired_d    = retired_q;
        step_cnt_d   = step_cnt_q;
        skip_d       = skip_q;
        bp_en_d      = bp_en_q;
        bp_addr_d    = bp_addr_q;

        if (fire_s && (op_s == CMD_SET_BP)) begin
            bp_addr_d = cmd_arg;
            bp_en_d   = 1'b1;
        end else if (fire_s && (op_s == CMD_CLR_BP)) begin
            bp_en_d   = 1'b0;
        end else begin
            bp_en_d   = bp_en_q;
        end

        if (fire_s && (op_s == CMD_CPU_RESET)) begin
            state_d      = ST_RST;
            rst_cnt_d    = RST_LOAD;
            retired_d    = {CNT_WIDTH{1'b0}};
            step_cnt_d   = {WIDTH{1'b0}};
            skip_d       = 1'b0;
            halt_cause_d = CAUSE_CMD;
        end else begin
            // skip only protects the first enabled cycle after leaving HALT
            if (cpu_en) begin
                retired_d = sat_inc(retired_q);
                skip_d    = 1'b0;
            end else begin
                retired_d = retired_q;
            end
            if (fire_s && (op_s == CMD_SET_BP)) begin
                skip_d = 1'b0;
            end else begin
                skip_d = skip_d;
            end

            case (state_q)
                ST_RST: begin
                    if (rst_cnt_q == {RC_W{1'b0}}) begin
                        state_d      = ST_HALT;
                        halt_cause_d = CAUSE_CMD;
                    end else begin
                        rst_cnt_d = rst_cnt_q - {{(RC_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_HALT: begin
                    if (fire_s && (op_s == CMD_RUN)) begin
                        state_d = ST_RUN;
                        skip_d  = 1'b1;
                    end else if (fire_s && (op_s == CMD_STEP)) begin
                        state_d    = ST_STEP;
                        step_cnt_d = (cmd_arg == {WIDTH{1'b0}}) ? STEP_ONE : cmd_arg;
                        skip_d     = 1'b1;
                    end else begin
                        state_d = ST_HALT;
                    end
                end
                ST_RUN, ST_STEP: begin
                    if (hlt_s) begin
                        state_d      = ST_STOP;
                        halt_cause_d = CAUSE_HLT;
                        step_cnt_d   = {WIDTH{1'b0}};
                    end else if (brk_s) begin
                        state_d      = ST_HALT;
                        halt_cause_d = CAUSE_BRK;
                        step_cnt_d   = {WIDTH{1'b0}};
                    end else if ((state_q == ST_STEP) && cpu_en && (step_cnt_q == STEP_ONE)) begin
                        state_d      = ST_HALT;
                        halt_cause_d = CAUSE_STEP;
                        step_cnt_d   = {WIDTH{1'b0}};
                    end else if (fire_s && (op_s == CMD_HALT)) begin
                        state_d      = ST_HALT;
                        halt_cause_d = CAUSE_CMD;
                        step_cnt_d   = {WIDTH{1'b0}};
                    end else if ((state_q == ST_STEP) && cpu_en) begin
                        step_cnt_d = step_cnt_q - STEP_ONE;
                    end else begin
                        state_d = state_q;
                    end
                end
                ST_STOP: begin
                    state_d = ST_STOP;
                end
                default: begin
                    state_d   = ST_RST;
                    rst_cnt_d = RST_LOAD;
                end
            endcase
        end

        cpu_rst_d   = (state_d == ST_RST);
        halted_d    = (state_d == ST_HALT) || (state_d == ST_STOP);
        cmd_ready_d = (state_d != ST_RST);
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_RST;
            rst_cnt_q    <= RST_LOAD;
            halt_cause_q <= CAUSE_CMD;
            retired_q    <= {CNT_WIDTH{1'b0}};
            step_cnt_q   <= {WIDTH{1'b0}};
            bp_en_q      <= 1'b0;
            bp_addr_q    <= {WIDTH{1'b0}};
            skip_q       <= 1'b0;
            cpu_rst_q    <= 1'b1;
            halted_q     <= 1'b0;
            cmd_ready_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            rst_cnt_q    <= rst_cnt_d;
            halt_cause_q <= halt_cause_d;
            retired_q    <= retired_d;
            step_cnt_q   <= step_cnt_d;
            bp_en_q      <= bp_en_d;
            bp_addr_q    <= bp_addr_d;
            skip_q       <= skip_d;
            cpu_rst_q    <= cpu_rst_d;
            halted_q     <= halted_d;
            cmd_ready_q  <= cmd_ready_d;
        end
    end

    assign cmd_ready  = cmd_ready_q;
    assign cpu_rst    = cpu_rst_q;
    assign halted     = halted_q;
    assign halt_cause = halt_cause_q;
    assign retired    = retired_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: directed scenarios then random commands, every cycle
// compared against a behavioural model; a 3-bit-counter instance covers saturation.
module tb_cpu_run_ctrl;

    localparam int M_RST = 0, M_HALT = 1, M_RUN = 2, M_STEP = 3, M_STOP = 4;
    localparam logic [2:0] OP_NOP = 3'd0, OP_RUN = 3'd1, OP_HALT = 3'd2, OP_STEP = 3'd3,
                           OP_CRST = 3'd4, OP_SETBP = 3'd5, OP_CLRBP = 3'd6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, cmd_valid;
    logic [2:0]  cmd_op;
    logic [7:0]  cmd_arg, pc, instr;
    logic        cmd_ready, cpu_en, cpu_rst, halted;
    logic [1:0]  halt_cause;
    logic [15:0] retired;
    logic        s_cmd_ready, s_cpu_en, s_cpu_rst, s_halted;
    logic [1:0]  s_halt_cause;
    logic [2:0]  s_retired;

    cpu_run_ctrl dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_arg(cmd_arg), .pc(pc), .instr(instr), .cpu_en(cpu_en),
        .cpu_rst(cpu_rst), .halted(halted), .halt_cause(halt_cause), .retired(retired)
    );

    cpu_run_ctrl #(.CNT_WIDTH(3)) dut_sat (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(s_cmd_ready),
        .cmd_op(cmd_op), .cmd_arg(cmd_arg), .pc(pc), .instr(instr), .cpu_en(s_cpu_en),
        .cpu_rst(s_cpu_rst), .halted(s_halted), .halt_cause(s_halt_cause), .retired(s_retired)
    );

    int errors = 0;
    int checks = 0;

    int m_mode, m_rst_left, m_cause, m_ret, m_steps, m_bp;
    bit m_bp_en, m_skip;
    int hlt_at = -1;
    logic [7:0] base_instr = 8'h00;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = M_RST; m_rst_left = 2; m_cause = 0; m_ret = 0;
        m_steps = 0; m_bp = 0; m_bp_en = 1'b0; m_skip = 1'b0;
    endtask

    // One clock cycle: drive command, compare every output, advance model and core PC.
    task automatic cyc(input logic v, input logic [2:0] op, input logic [7:0] arg);
        bit ready, fire, brk, hlt, en;
        logic d_en, d_rst;
        cmd_valid = v; cmd_op = op; cmd_arg = arg;
        instr = (hlt_at >= 0 && int'(pc) == hlt_at) ? 8'hFF : base_instr;
        #1;
        ready = (m_mode != M_RST);
        fire  = v && ready;
        brk   = m_bp_en && (int'(pc) == m_bp) && !m_skip;
        hlt   = (instr == 8'hFF);
        en    = (m_mode == M_RUN || m_mode == M_STEP) && !brk && !hlt;
        check("cpu_en", {31'd0, cpu_en}, {31'd0, en});
        check("cmd_ready", {31'd0, cmd_ready}, {31'd0, ready});
        check("cpu_rst", {31'd0, cpu_rst}, {31'd0, m_mode == M_RST});
        check("halted", {31'd0, halted}, {31'd0, m_mode == M_HALT || m_mode == M_STOP});
        check("halt_cause", {30'd0, halt_cause}, 32'(m_cause));
        check("retired", {16'd0, retired}, 32'((m_ret > 65535) ? 65535 : m_ret));
        check("retired_sat", {29'd0, s_retired}, 32'((m_ret > 7) ? 7 : m_ret));

        if (m_mode == M_RST) begin
            m_rst_left--;
            if (m_rst_left == 0) begin m_mode = M_HALT; m_cause = 0; end
        end else if (fire && op == OP_CRST) begin
            m_mode = M_RST; m_rst_left = 2; m_ret = 0; m_steps = 0; m_skip = 0; m_cause = 0;
        end else begin
            if (en) begin m_ret++; m_skip = 0; end
            if (fire && op == OP_SETBP) begin m_bp = int'(arg); m_bp_en = 1; m_skip = 0; end
            if (fire && op == OP_CLRBP) m_bp_en = 0;
            if (m_mode == M_HALT) begin
                if (fire && op == OP_RUN) begin m_mode = M_RUN; m_skip = 1; end
                else if (fire && op == OP_STEP) begin
                    m_mode = M_STEP; m_steps = (arg == 8'd0) ? 1 : int'(arg); m_skip = 1;
                end
            end else if (m_mode == M_RUN || m_mode == M_STEP) begin
                if (hlt) begin m_mode = M_STOP; m_cause = 3; m_steps = 0; end
                else if (brk) begin m_mode = M_HALT; m_cause = 1; m_steps = 0; end
                else if (m_mode == M_STEP && en && m_steps == 1) begin m_mode = M_HALT; m_cause = 2; m_steps = 0; end
                else if (fire && op == OP_HALT) begin m_mode = M_HALT; m_cause = 0; m_steps = 0; end
                else if (m_mode == M_STEP && en) m_steps--;
            end
        end

        d_en = cpu_en; d_rst = cpu_rst;
        @(posedge clk);
        #1;
        if (d_rst) pc = 8'd0;
        else if (d_en) pc = pc + 8'd1;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, OP_NOP, 8'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rcnt;
        logic [2:0] rop;
        logic       rv;
        logic [7:0] rarg;

        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_arg = 8'd0;
        pc = 8'd0; instr = 8'd0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_cpu_rst", {31'd0, cpu_rst}, 32'd1);
        check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        check("rst_cpu_en", {31'd0, cpu_en}, 32'd0);
        check("rst_retired", {16'd0, retired}, 32'd0);
        rst_n = 1'b1;
        idle(2);
        check("post_rst_halted", {31'd0, halted}, 32'd1);
        check("post_rst_ready", {31'd0, cmd_ready}, 32'd1);

        // Breakpoint at 5, then resume through it.
        cyc(1'b1, OP_SETBP, 8'h05);
        cyc(1'b1, OP_RUN, 8'd0);
        idle(10);
        check("bp_cause", {30'd0, halt_cause}, 32'd1);
        check("bp_retired", {16'd0, retired}, 32'd5);
        check("bp_pc", {24'd0, pc}, 32'd5);
        cyc(1'b1, OP_RUN, 8'd0);
        idle(3);
        check("bp_resume_pc", {24'd0, pc}, 32'd8);
        cyc(1'b1, OP_HALT, 8'd0);
        cyc(1'b1, OP_CLRBP, 8'd0);
        check("halt_cmd_retired", {16'd0, retired}, 32'd9);

        // Step 3, step 0.
        cyc(1'b1, OP_STEP, 8'd3);
        idle(6);
        check("step3_retired", {16'd0, retired}, 32'd12);
        check("step3_cause", {30'd0, halt_cause}, 32'd2);
        cyc(1'b1, OP_STEP, 8'd0);
        idle(3);
        check("step0_retired", {16'd0, retired}, 32'd13);

        // HLT opcode at pc 2, sticky STOP, CPU_RESET exits.
        cyc(1'b1, OP_CRST, 8'd0);
        idle(3);
        hlt_at = 2;
        cyc(1'b1, OP_RUN, 8'd0);
        idle(6);
        check("hlt_cause", {30'd0, halt_cause}, 32'd3);
        check("hlt_retired", {16'd0, retired}, 32'd2);
        cyc(1'b1, OP_RUN, 8'd0);
        cyc(1'b1, OP_STEP, 8'd4);
        idle(2);
        check("stop_sticky", {31'd0, halted}, 32'd1);
        cyc(1'b1, OP_CRST, 8'd0);
        check("crst_rst", {31'd0, cpu_rst}, 32'd1);
        check("crst_retired", {16'd0, retired}, 32'd0);
        hlt_at = -1;
        idle(3);

        // HALT command in the same cycle the breakpoint fires.
        cyc(1'b1, OP_SETBP, 8'h03);
        cyc(1'b1, OP_RUN, 8'd0);
        for (int i = 0; i < 10; i++) begin
            if (pc == 8'd3) break;
            cyc(1'b0, OP_NOP, 8'd0);
        end
        check("brk_reach", {24'd0, pc}, 32'd3);
        cyc(1'b1, OP_HALT, 8'd0);
        check("brk_halt_cause", {30'd0, halt_cause}, 32'd1);
        cyc(1'b1, OP_CLRBP, 8'd0);

        // CPU_RESET mid-STEP holds cpu_rst for exactly 2 cycles.
        cyc(1'b1, OP_STEP, 8'd10);
        idle(2);
        cyc(1'b1, OP_CRST, 8'd0);
        rcnt = 0;
        for (int i = 0; i < 6; i++) begin
            if (cpu_rst) rcnt++;
            cyc(1'b0, OP_NOP, 8'd0);
        end
        check("crst_len", 32'(rcnt), 32'd2);

        // Saturation on the narrow instance, then async reset mid-RUN.
        cyc(1'b1, OP_RUN, 8'd0);
        idle(10);
        check("sat_retired", {29'd0, s_retired}, 32'd7);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_cpu_en", {31'd0, cpu_en}, 32'd0);
        check("async_cpu_rst", {31'd0, cpu_rst}, 32'd1);
        check("async_retired", {16'd0, retired}, 32'd0);
        model_reset();
        pc = 8'd0;
        @(negedge clk);
        rst_n = 1'b1;

        // Random commands and opcodes.
        for (int i = 0; i < 500; i++) begin
            base_instr = ($urandom_range(0, 19) == 0) ? 8'hFF : 8'($urandom_range(0, 254));
            rv = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 99) < 8) rop = OP_CRST;
            else begin
                rop = 3'($urandom_range(0, 7));
                if (rop == OP_CRST) rop = OP_RUN;
            end
            if (rop == OP_SETBP) rarg = pc + 8'($urandom_range(0, 6));
            else rarg = 8'($urandom_range(0, 5));
            cyc(rv, rop, rarg);
        end
        base_instr = 8'h00;
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
